// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU types: store access size encoding and the lane-steered write
// payload carried through the store buffer.
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;

   // sb/sh/sw size field; 2'b11 is reserved and never reaches memory
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } st_size_t;

   // Write data already replicated onto the target lanes, plus byte enables
   typedef struct packed {
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } lane_t;

endpackage

// File: rtl/store_lane_align.sv
// ---------------------------------------------------------------------------
// store_lane_align
// Purely combinational lane steering for sb/sh/sw. Replicates the narrowed
// rt value across the word and selects byte enables from the low address bits.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word flagged bad).
// Ports:
//   size     in   store size (st_size_t)
//   addrLo   in   byte address bits [1:0]
//   data     in   unaligned rt value
//   wdata_c  out  lane-replicated write data
//   be_c     out  byte enables, bit i = byte [8i+7:8i]
//   bad_c    out  store must not be enqueued (reserved size or trapped misalign)
// ---------------------------------------------------------------------------
module store_lane_align
   import cpu_pkg::*;
(
   input  st_size_t          size,
   input  logic [1:0]        addrLo,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] wdata_c,
   output logic [BE_W-1:0]   be_c,
   output logic              bad_c
);

   // Replicate and select lanes; misaligned bits only matter when trapping
   always_comb begin
      wdata_c = data;
      be_c    = '0;
      bad_c   = 1'b0;
      case (size)
         SZ_BYTE: begin
            wdata_c = {4{data[7:0]}};
            be_c    = BE_W'(4'b0001 << addrLo);
         end
         SZ_HALF: begin
            wdata_c = {2{data[15:0]}};
            be_c    = addrLo[1] ? 4'b1100 : 4'b0011;
`ifdef MISALIGN_TRAP_EN
            bad_c   = addrLo[0];
`endif
         end
         SZ_WORD: begin
            wdata_c = data;
            be_c    = 4'b1111;
`ifdef MISALIGN_TRAP_EN
            bad_c   = |addrLo;
`endif
         end
         default: begin
            bad_c   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/store_lane_buffer.sv
// ---------------------------------------------------------------------------
// store_lane_buffer
// Store write buffer between the register-file rt read port and the data
// memory write port. Stores are lane-steered on entry and queued in a DEPTH
// entry FIFO so memory back-pressure does not stall the core.
// Optional feature macro: MISALIGN_TRAP_EN (drop misaligned sh/sw, pulse misalign).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   st_valid/st_ready     store request handshake
//   st_size/addr/data     store size, byte address, raw rt value
//   mem_valid/mem_ready   head-entry handshake toward memory
//   mem_addr/wdata/be     word address, steered data, byte enables
//   buf_empty             no buffered stores (load ordering / fence)
//   misalign              one-cycle pulse on a dropped misaligned store
// ---------------------------------------------------------------------------
module store_lane_buffer
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [1:0]        st_size,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_data,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [BE_W-1:0]   mem_be,
   output logic              buf_empty,
   output logic              misalign
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam int unsigned WADDR_W = ADDR_W - 2;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   st_size_t           sizeIn;
   logic [DATA_W-1:0]  alignWdata;
   logic [BE_W-1:0]    alignBe;
   logic               alignBad;
   lane_t              newLane;

   lane_t              laneMem [DEPTH];
   logic [WADDR_W-1:0] addrMem [DEPTH];

   logic [PTR_W-1:0]   rdPtr;
   logic [PTR_W-1:0]   wrPtr;
   logic [PTR_W-1:0]   rdPtrNext;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   countNext;
   logic               accept;
   logic               push;
   logic               pop;
   logic               headFromInput;
   lane_t              headLane;
   logic [WADDR_W-1:0] headAddr;

   assign sizeIn  = st_size_t'(st_size);
   assign newLane = '{wdata: alignWdata, be: alignBe};

   store_lane_align u_align (
      .size    (sizeIn),
      .addrLo  (st_addr[1:0]),
      .data    (st_data),
      .wdata_c (alignWdata),
      .be_c    (alignBe),
      .bad_c   (alignBad)
   );

   // Handshakes, occupancy and the head entry that mem_* will present next cycle
   always_comb begin
      accept    = st_valid & st_ready;
      push      = accept & ~alignBad;
      pop       = mem_valid & mem_ready;
      countNext = count;
      if (push && !pop) begin
         countNext = count + CNT_W'(1);
      end else if (!push && pop) begin
         countNext = count - CNT_W'(1);
      end
      rdPtrNext = pop ? rdPtr + PTR_W'(1) : rdPtr;
      // The entry being written becomes the head only when nothing else remains
      headFromInput = push && (count == (pop ? CNT_W'(1) : CNT_W'(0)));
      headLane      = headFromInput ? newLane : laneMem[rdPtrNext];
      headAddr      = headFromInput ? st_addr[ADDR_W-1:2] : addrMem[rdPtrNext];
   end

   // Entry storage; control state alone decides which entries are live
   always_ff @(posedge clk) begin
      if (push) begin
         laneMem[wrPtr] <= newLane;
         addrMem[wrPtr] <= st_addr[ADDR_W-1:2];
      end
   end

   // Pointers, count and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdPtr     <= '0;
         wrPtr     <= '0;
         count     <= '0;
         st_ready  <= 1'b0;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         buf_empty <= 1'b1;
      end else begin
         rdPtr     <= rdPtrNext;
         if (push) begin
            wrPtr  <= wrPtr + PTR_W'(1);
         end
         count     <= countNext;
         st_ready  <= (countNext != FULL_CNT);
         mem_valid <= (countNext != '0);
         buf_empty <= (countNext == '0);
         if (countNext != '0) begin
            mem_addr  <= {headAddr, 2'b00};
            mem_wdata <= headLane.wdata;
            mem_be    <= headLane.be;
         end
      end
   end

`ifdef MISALIGN_TRAP_EN
   // Pulse once for an accepted store dropped for alignment, not for reserved size
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         misalign <= 1'b0;
      end else begin
         misalign <= accept & alignBad & (sizeIn != SZ_RSVD);
      end
   end
`else
   assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_store_lane_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_lane_buffer
// Self-checking bench for store_lane_buffer: directed vector table, corner
// sequences (full, pop-while-full, reset flush, misaligned word) and random
// traffic against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_store_lane_buffer;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 32;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } exp_t;

   typedef struct {
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] eAddr;
      logic [31:0] eWdata;
      logic [3:0]  eBe;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_valid;
   logic        st_ready;
   logic [1:0]  st_size;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        buf_empty;
   logic        misalign;

   int checks = 0;
   int errors = 0;

   exp_t q[$];
   bit   mReady  = 1'b0;
   bit   mMis    = 1'b0;
   bit   inReset = 1'b1;

   always #5 clk = ~clk;

   store_lane_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_size   (st_size),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .buf_empty (buf_empty),
      .misalign  (misalign)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // What a store should look like at the memory port, from the size rules
   function automatic void lane_rule(input logic [1:0] sz, input logic [31:0] addr,
                                     input logic [31:0] data, output bit enq,
                                     output bit mis, output exp_t e);
      int unsigned a;
      a       = addr % 4;
      e.addr  = addr - a;
      e.wdata = data;
      e.be    = 4'hF;
      enq     = 1'b1;
      mis     = 1'b0;
      case (sz)
         2'd0: begin
            e.wdata = (data % 256) * 32'h01010101;
            e.be    = 4'(1 << a);
         end
         2'd1: begin
            e.wdata = (data % 65536) * 32'h00010001;
            e.be    = (a >= 2) ? 4'hC : 4'h3;
`ifdef MISALIGN_TRAP_EN
            if (a % 2 == 1) begin
               enq = 1'b0;
               mis = 1'b1;
            end
`endif
         end
         2'd2: begin
`ifdef MISALIGN_TRAP_EN
            if (a != 0) begin
               enq = 1'b0;
               mis = 1'b1;
            end
`endif
         end
         default: enq = 1'b0;
      endcase
   endfunction

   // Advance the model over one clock edge, then compare every output
   task automatic step();
      bit   acc;
      bit   pop;
      bit   enq;
      bit   mis;
      exp_t e;
      acc = (rst_n === 1'b1) && (st_valid === 1'b1) && mReady;
      pop = (rst_n === 1'b1) && (q.size() != 0) && (mem_ready === 1'b1);
      if (rst_n !== 1'b1) begin
         q.delete();
         mReady = 1'b0;
         mMis   = 1'b0;
      end else begin
         if (pop) void'(q.pop_front());
         mis = 1'b0;
         if (acc) begin
            lane_rule(st_size, st_addr, st_data, enq, mis, e);
            if (enq) q.push_back(e);
         end
         mReady = (q.size() != DEPTH);
         mMis   = mis;
      end
      inReset = (rst_n !== 1'b1);
      @(posedge clk);
      #1;
      chk("st_ready",  32'(st_ready),  32'(mReady));
      chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
      chk("buf_empty", 32'(buf_empty), 32'(q.size() == 0));
      chk("misalign",  32'(misalign),  32'(mMis));
      if (inReset) begin
         chk("rst_mem_addr",  mem_addr,      32'h0);
         chk("rst_mem_wdata", mem_wdata,     32'h0);
         chk("rst_mem_be",    32'(mem_be),   32'h0);
      end else if (q.size() != 0) begin
         chk("mem_addr",  mem_addr,    q[0].addr);
         chk("mem_wdata", mem_wdata,   q[0].wdata);
         chk("mem_be",    32'(mem_be), 32'(q[0].be));
      end
   endtask

   initial begin
      vec_t vecs [7];
      int   readyPct;

      vecs[0] = '{2'd0, 32'h0000_1003, 32'hAABBCCDD, 32'h0000_1000, 32'hDDDDDDDD, 4'b1000};
      vecs[1] = '{2'd1, 32'h0000_2002, 32'h12345678, 32'h0000_2000, 32'h56785678, 4'b1100};
      vecs[2] = '{2'd2, 32'h0000_3000, 32'hCAFEF00D, 32'h0000_3000, 32'hCAFEF00D, 4'b1111};
      vecs[3] = '{2'd0, 32'h0000_5000, 32'h00000011, 32'h0000_5000, 32'h11111111, 4'b0001};
      vecs[4] = '{2'd0, 32'h0000_7002, 32'h000000EE, 32'h0000_7000, 32'hEEEEEEEE, 4'b0100};
      vecs[5] = '{2'd1, 32'h0000_8000, 32'hFFFF0001, 32'h0000_8000, 32'h00010001, 4'b0011};
      vecs[6] = '{2'd0, 32'hFFFF_FFFD, 32'h0000007F, 32'hFFFF_FFFC, 32'h7F7F7F7F, 4'b0010};

      rst_n     = 1'b0;
      st_valid  = 1'b0;
      st_size   = 2'd0;
      st_addr   = 32'h0;
      st_data   = 32'h0;
      mem_ready = 1'b0;

      // Reset state
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("ready_after_reset", 32'(st_ready), 32'd1);

      // Directed lane-steering vectors: accept, check next cycle, then drain
      mem_ready = 1'b1;
      foreach (vecs[i]) begin
         st_valid = 1'b1;
         st_size  = vecs[i].sz;
         st_addr  = vecs[i].addr;
         st_data  = vecs[i].data;
         step();
         st_valid = 1'b0;
         chk($sformatf("vec%0d_valid", i), 32'(mem_valid), 32'd1);
         chk($sformatf("vec%0d_addr", i),  mem_addr,       vecs[i].eAddr);
         chk($sformatf("vec%0d_wdata", i), mem_wdata,      vecs[i].eWdata);
         chk($sformatf("vec%0d_be", i),    32'(mem_be),    32'(vecs[i].eBe));
         step();
      end

      // Reserved size is swallowed
      st_valid = 1'b1;
      st_size  = 2'd3;
      st_addr  = 32'h0000_9000;
      st_data  = 32'h1234_5678;
      step();
      st_valid = 1'b0;
      chk("rsvd_no_write", 32'(mem_valid), 32'd0);

      // Back-pressure: DEPTH+1 back-to-back stores, only DEPTH accepted
      mem_ready = 1'b0;
      st_valid  = 1'b1;
      st_size   = 2'd2;
      for (int i = 0; i < DEPTH + 1; i++) begin
         st_addr = 32'h0000_0100 + 32'(i * 4);
         st_data = 32'hC0DE_0000 + 32'(i);
         step();
      end
      chk("full_st_ready", 32'(st_ready), 32'd0);
      chk("full_not_empty", 32'(buf_empty), 32'd0);

      // Full with valid store and ready memory: pop only
      st_addr   = 32'h0000_0BAD;
      st_data   = 32'hBAD0_0000;
      mem_ready = 1'b1;
      step();
      chk("pop_only_ready", 32'(st_ready), 32'd1);
      chk("pop_only_head", mem_wdata, 32'hC0DE_0001);
      st_valid = 1'b0;
      for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) step();
      chk("drain_empty", 32'(buf_empty), 32'd1);

      // Reset with three entries buffered
      mem_ready = 1'b0;
      st_valid  = 1'b1;
      st_size   = 2'd0;
      for (int i = 0; i < 3; i++) begin
         st_addr = 32'h0000_0200 + 32'(i);
         st_data = 32'h0000_00A0 + 32'(i);
         step();
      end
      st_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      chk("flush_mem_valid", 32'(mem_valid), 32'd0);
      chk("flush_buf_empty", 32'(buf_empty), 32'd1);
      rst_n     = 1'b1;
      mem_ready = 1'b1;
      step();
      step();
      chk("no_stale_reissue", 32'(mem_valid), 32'd0);

      // Misaligned word store
      st_valid = 1'b1;
      st_size  = 2'd2;
      st_addr  = 32'h0000_4001;
      st_data  = 32'h0BAD_CAFE;
      step();
      st_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
      chk("mis_pulse", 32'(misalign), 32'd1);
      chk("mis_no_write", 32'(mem_valid), 32'd0);
      step();
      chk("mis_pulse_end", 32'(misalign), 32'd0);
      chk("mis_still_idle", 32'(mem_valid), 32'd0);
`else
      chk("mis_word_valid", 32'(mem_valid), 32'd1);
      chk("mis_word_addr", mem_addr, 32'h0000_4000);
      chk("mis_word_be", 32'(mem_be), 32'hF);
      chk("mis_flag_low", 32'(misalign), 32'd0);
      step();
`endif

      // Random traffic with varying memory back-pressure and rare resets
      readyPct = 30;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 500 == 0) readyPct = (readyPct == 30) ? 85 : 30;
         rst_n     = ($urandom_range(0, 199) != 0);
         st_valid  = ($urandom_range(0, 3) != 0);
         st_size   = 2'($urandom_range(0, 3));
         st_addr   = $urandom;
         st_data   = $urandom;
         mem_ready = ($urandom_range(0, 99) < readyPct);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
